// File: rtl/coin_vendor_if.sv
// coin_vendor_if: customer-facing signal bundle of the coin vending controller.
// The master side (coin acceptor / test harness) presents coins and cancel
// requests; the slave side (coin_vendor) reports dispense, change, credit,
// busy and coin-reject status.
interface coin_vendor_if #(
  parameter int CW = 4
) ();

  logic [1:0]    coin;
  logic          cancel;
  logic          vend;
  logic [1:0]    change_coin;
  logic [CW-1:0] credit;
  logic          busy;
  logic          coin_reject;

  modport master (
    output coin,
    output cancel,
    input  vend,
    input  change_coin,
    input  credit,
    input  busy,
    input  coin_reject
  );

  modport slave (
    input  coin,
    input  cancel,
    output vend,
    output change_coin,
    output credit,
    output busy,
    output coin_reject
  );

endinterface

// File: rtl/coin_vendor.sv
// coin_vendor: Moore vending controller.
//   States: IDLE -> COLLECT (credit below PRICE) -> VEND (one-cycle dispense)
//   -> CHANGE (greedy 2/1-unit refund, one coin per cycle) -> IDLE.
//   Coins presented while busy are ignored and flagged on coin_reject the
//   following cycle. Every output is a flop loaded from the next state and
//   next credit, so outputs depend on state and credit only.
// Build option:
//   CANCEL_EN  - when defined, cancel in COLLECT refunds the whole credit
//                through CHANGE without vending. When undefined, cancel is
//                ignored (the port still exists on the interface).
// PRICE must lie in 1..(2^CW - 5) so credit never exceeds PRICE + 4 and the
// CW-bit arithmetic never wraps.
module coin_vendor #(
  parameter int PRICE = 5,
  parameter int CW    = 4
) (
  input  logic         clk,
  input  logic         rst,
  coin_vendor_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_VEND    = 2'b10,
    ST_CHANGE  = 2'b11
  } state_e;

  // Price widened by one bit so the credit + coin comparison cannot overflow.
  localparam logic [CW:0]   PRICE_X  = (CW+1)'(PRICE);
  localparam logic [CW-1:0] CRED_ONE = CW'(32'd1);
  localparam logic [CW-1:0] CRED_TWO = CW'(32'd2);
  localparam logic [CW-1:0] CRED_ZERO = CW'(32'd0);

  // Coin code to value in units: 00 none, 01 one, 10 two, 11 five.
  function automatic logic [2:0] coin_value(input logic [1:0] code);
    logic [2:0] val;
    case (code)
      2'b00:   val = 3'd0;
      2'b01:   val = 3'd1;
      2'b10:   val = 3'd2;
      2'b11:   val = 3'd5;
      default: val = 3'd0;
    endcase
    return val;
  endfunction

  // Greedy change coin for a given remaining credit: 2 units while possible.
  function automatic logic [1:0] change_code(input logic [CW-1:0] cred);
    logic [1:0] code;
    if (cred >= CRED_TWO) begin
      code = 2'b10;
    end else if (cred == CRED_ONE) begin
      code = 2'b01;
    end else begin
      code = 2'b00;
    end
    return code;
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          vend_q, vend_d;
  logic [1:0]    change_coin_q, change_coin_d;
  logic          busy_q, busy_d;
  logic          coin_reject_q, coin_reject_d;

  logic [2:0]    coin_val_s;
  logic          coin_present_s;
  logic [CW:0]   sum_s;
  logic          cancel_s;

  assign coin_val_s     = coin_value(bus.coin);
  assign coin_present_s = (bus.coin != 2'b00);
  assign sum_s          = {1'b0, credit_q} + {{(CW-2){1'b0}}, coin_val_s};

`ifdef CANCEL_EN
  assign cancel_s = bus.cancel;
`else
  // Refund path compiled out: the request is deliberately dropped.
  logic cancel_unused_s;
  assign cancel_unused_s = bus.cancel;
  assign cancel_s        = 1'b0;
`endif

  // Next-state and next-credit logic for the vending sequence.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    coin_reject_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (cancel_s && (state_q == ST_COLLECT)) begin
          // Refund takes priority; a coin offered alongside it is refused.
          state_d       = ST_CHANGE;
          credit_d      = credit_q;
          coin_reject_d = coin_present_s;
        end else if (coin_present_s) begin
          if (sum_s >= PRICE_X) begin
            state_d  = ST_VEND;
            credit_d = CW'(sum_s - PRICE_X);
          end else begin
            state_d  = ST_COLLECT;
            credit_d = sum_s[CW-1:0];
          end
        end else begin
          state_d  = state_q;
          credit_d = credit_q;
        end
      end
      ST_VEND: begin
        coin_reject_d = coin_present_s;
        if (credit_q != CRED_ZERO) begin
          state_d = ST_CHANGE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHANGE: begin
        coin_reject_d = coin_present_s;
        if (credit_q > CRED_TWO) begin
          credit_d = credit_q - CRED_TWO;
          state_d  = ST_CHANGE;
        end else if (credit_q == CRED_TWO) begin
          credit_d = CRED_ZERO;
          state_d  = ST_IDLE;
        end else if (credit_q == CRED_ONE) begin
          credit_d = CRED_ZERO;
          state_d  = ST_IDLE;
        end else begin
          // Nothing left to return; recover to IDLE.
          credit_d = CRED_ZERO;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = CRED_ZERO;
      end
    endcase
  end

  // Output decode from the upcoming state and credit, loaded into output flops.
  always_comb begin
    vend_d        = 1'b0;
    change_coin_d = 2'b00;
    busy_d        = 1'b0;
    case (state_d)
      ST_IDLE: begin
        vend_d        = 1'b0;
        change_coin_d = 2'b00;
        busy_d        = 1'b0;
      end
      ST_COLLECT: begin
        vend_d        = 1'b0;
        change_coin_d = 2'b00;
        busy_d        = 1'b0;
      end
      ST_VEND: begin
        vend_d        = 1'b1;
        change_coin_d = 2'b00;
        busy_d        = 1'b1;
      end
      ST_CHANGE: begin
        vend_d        = 1'b0;
        change_coin_d = change_code(credit_d);
        busy_d        = 1'b1;
      end
      default: begin
        vend_d        = 1'b0;
        change_coin_d = 2'b00;
        busy_d        = 1'b0;
      end
    endcase
  end

  // State and credit registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      credit_q <= CRED_ZERO;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
    end
  end

  // Registered customer-facing outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vend_q        <= 1'b0;
      change_coin_q <= 2'b00;
      busy_q        <= 1'b0;
      coin_reject_q <= 1'b0;
    end else begin
      vend_q        <= vend_d;
      change_coin_q <= change_coin_d;
      busy_q        <= busy_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  assign bus.vend        = vend_q;
  assign bus.change_coin = change_coin_q;
  assign bus.credit      = credit_q;
  assign bus.busy        = busy_q;
  assign bus.coin_reject = coin_reject_q;

endmodule

// File: tb/tb_coin_vendor.sv
// tb_coin_vendor: directed scenarios followed by random coin/cancel/reset
// traffic, compared each cycle against a transaction-level model that keeps
// the accumulated credit and a queue of the busy cycles still to come.
module tb_coin_vendor;

  localparam int PRICE = 5;
  localparam int CW    = 4;

`ifdef CANCEL_EN
  localparam bit CANCEL_ON = 1'b1;
`else
  localparam bit CANCEL_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  coin_vendor_if #(.CW(CW)) bus ();

  coin_vendor #(.PRICE(PRICE), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int vend;
    int chg;
    int credit;
    int busy;
  } out_t;

  out_t cur;
  out_t plan[$];
  int   m_credit;
  int   m_reject;
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic out_t idle_out(input int c);
    out_t o;
    o.vend = 0; o.chg = 0; o.credit = c; o.busy = 0;
    return o;
  endfunction

  // Append one refund cycle per coin, biggest coin first.
  task automatic plan_change(input int r);
    out_t o;
    while (r > 0) begin
      o.vend   = 0;
      o.busy   = 1;
      o.credit = r;
      o.chg    = (r >= 2) ? 2 : 1;
      plan.push_back(o);
      r = r - o.chg;
    end
  endtask

  task automatic model_reset();
    plan.delete();
    m_credit = 0;
    m_reject = 0;
    cur      = idle_out(0);
  endtask

  task automatic model_step(input logic [1:0] c, input logic k);
    int v;
    v = (c == 2'b11) ? 5 : int'(c);
    m_reject = 0;
    if (cur.busy != 0) begin
      m_reject = (v != 0);
      if (plan.size() > 0) cur = plan.pop_front();
      else cur = idle_out(0);
    end else if (CANCEL_ON && (m_credit > 0) && k) begin
      m_reject = (v != 0);
      plan_change(m_credit);
      m_credit = 0;
      cur = plan.pop_front();
    end else if (v != 0) begin
      if (m_credit + v >= PRICE) begin
        cur.vend   = 1;
        cur.chg    = 0;
        cur.busy   = 1;
        cur.credit = m_credit + v - PRICE;
        plan_change(cur.credit);
        m_credit = 0;
      end else begin
        m_credit = m_credit + v;
        cur = idle_out(m_credit);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".vend"},   32'(bus.vend),        32'(cur.vend));
    check({tag, ".change"}, 32'(bus.change_coin), 32'(cur.chg));
    check({tag, ".credit"}, 32'(bus.credit),      32'(cur.credit));
    check({tag, ".busy"},   32'(bus.busy),        32'(cur.busy));
    check({tag, ".reject"}, 32'(bus.coin_reject), 32'(m_reject));
  endtask

  task automatic step(input string tag, input logic [1:0] c, input logic k);
    bus.coin   = c;
    bus.cancel = k;
    @(posedge clk);
    model_step(c, k);
    #1;
    check_outputs(tag);
  endtask

  // Assert reset mid-cycle and check outputs clear before any clock edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs(tag);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int busy_cycles;
    int vend_seen;
    logic [1:0] rc;
    logic rk;

    rst        = 1'b1;
    bus.coin   = 2'b00;
    bus.cancel = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Exact-price purchase from small coins, no change.
    step("s1a", 2'b01, 1'b0);
    check("s1a.credit_abs", 32'(bus.credit), 32'd1);
    step("s1b", 2'b10, 1'b0);
    check("s1b.credit_abs", 32'(bus.credit), 32'd3);
    step("s1c", 2'b10, 1'b0);
    check("s1c.vend_abs", 32'(bus.vend), 32'd1);
    step("s1d", 2'b00, 1'b0);
    step("s1e", 2'b00, 1'b0);

    // Overpay by four: vend then two 2-unit change coins, busy for 3 cycles.
    repeat (4) step("s2c", 2'b01, 1'b0);
    busy_cycles = 0;
    step("s2v", 2'b11, 1'b0);
    check("s2v.credit_abs", 32'(bus.credit), 32'd4);
    busy_cycles += int'(bus.busy);
    repeat (3) begin
      step("s2r", 2'b00, 1'b0);
      busy_cycles += int'(bus.busy);
    end
    check("s2.busy_cycles", 32'(busy_cycles), 32'd3);

    // Five-unit coin from idle, another coin during VEND gets rejected.
    step("s3v", 2'b11, 1'b0);
    step("s3r", 2'b10, 1'b0);
    check("s3r.reject_abs", 32'(bus.coin_reject), 32'd1);
    step("s3i", 2'b00, 1'b0);

    // Cancel after 3 units: refund (or hold credit without refund path).
    step("s4a", 2'b01, 1'b0);
    step("s4b", 2'b10, 1'b0);
    vend_seen = 0;
    step("s4c", 2'b00, 1'b1);
    vend_seen += int'(bus.vend);
    repeat (3) begin
      step("s4d", 2'b00, 1'b0);
      vend_seen += int'(bus.vend);
    end
    check("s4.no_vend", 32'(vend_seen), 32'd0);
    // Clear any credit left over when the refund path is absent.
    step("s4e", 2'b11, 1'b0);
    repeat (4) step("s4f", 2'b00, 1'b0);

    // Cancel together with a coin: cancel wins, coin refused.
    step("s5a", 2'b10, 1'b0);
    step("s5b", 2'b01, 1'b1);
    repeat (3) step("s5c", 2'b00, 1'b0);
    async_reset("s5r");

    // Reset mid-CHANGE with credit 2 forfeits the change.
    repeat (4) step("s6c", 2'b01, 1'b0);
    step("s6v", 2'b11, 1'b0);
    step("s6x", 2'b00, 1'b0);
    step("s6y", 2'b00, 1'b0);
    check("s6y.credit_abs", 32'(bus.credit), 32'd2);
    async_reset("s6rst");
    step("s6n", 2'b01, 1'b0);
    check("s6n.credit_abs", 32'(bus.credit), 32'd1);

    // Random traffic with occasional cancel and reset.
    for (int i = 0; i < 600; i++) begin
      rc = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      rk = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rnd_rst");
      end
      step("rnd", rc, rk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/coin_vendor.md
COIN_VENDOR -- requirements
Module: coin_vendor

Interface
REQ-001 Parameter: PRICE, default 5, item price in 1-unit coins; legal range 1..(2^CW - 5).
REQ-002 Parameter: CW, default 4, credit register width in bits.
REQ-003 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: coin  input  2  coin sampled each cycle: 00 = none, 01 = 1 unit, 10 = 2 units, 11 = 5 units.
REQ-006 Port: cancel  input  1  refund request, level sampled each cycle (active only with CANCEL_EN).
REQ-007 Port: vend  output  1  one-cycle item-dispense pulse.
REQ-008 Port: change_coin  output  2  change being returned this cycle: 00 = none, 01 = 1 unit, 10 = 2 units; 11 is never driven.
REQ-009 Port: credit  output  CW  current accumulated credit, in units.
REQ-010 Port: busy  output  1  high while in VEND or CHANGE.
REQ-011 Port: coin_reject  output  1  one-cycle pulse, the cycle after a coin was presented while busy.

Function
REQ-012 The block SHALL implement states IDLE, COLLECT, VEND and CHANGE, and all outputs SHALL be registered or decoded from state and credit only (Moore).
REQ-013 In IDLE or COLLECT, a nonzero coin SHALL add its value to credit at the sampling edge; one coin is accepted per cycle.
REQ-014 If credit plus the coin value is less than PRICE, the next state SHALL be COLLECT; if credit stays 0, the state SHALL stay IDLE.
REQ-015 If credit plus the coin value is at least PRICE, then at the same edge the next state SHALL be VEND and credit SHALL become credit + value - PRICE.
REQ-016 Latency SHALL be as follows: vend is high for exactly the one cycle following the qualifying edge.
REQ-017 After VEND, the next state SHALL be CHANGE if credit > 0, otherwise IDLE.
REQ-018 In CHANGE, the block SHALL return change greedily, one coin per cycle:
- credit >= 2: change_coin = 10 and credit decreases by 2;
- credit = 1: change_coin = 01 and credit decreases by 1.
REQ-019 When credit reaches 0 in CHANGE, the next state SHALL be IDLE; change_coin SHALL be 00 outside CHANGE.
REQ-020 A nonzero coin sampled in VEND or CHANGE SHALL NOT alter credit, and coin_reject SHALL pulse for one cycle per rejected coin.
REQ-021 Credit arithmetic SHALL be unsigned CW-bit; by REQ-001 it never exceeds PRICE + 4 and never wraps.
REQ-022 A level-held coin SHALL be counted once per cycle; no edge detection is performed.

Reset
REQ-023 Asserting rst SHALL immediately force state IDLE, credit 0, vend 0, change_coin 00, busy 0 and coin_reject 0, regardless of clk.
REQ-024 Reset during VEND or CHANGE SHALL abandon the transaction; the remaining change is forfeited.
REQ-025 The first edge after rst deasserts SHALL process coin normally.

Configuration
REQ-026 Macro CANCEL_EN SHALL compile the refund path in or out.
- Defined: in COLLECT with cancel = 1, the next state SHALL be CHANGE with credit unchanged, so the full credit is refunded per REQ-018 and vend does not pulse.
- Defined, same cycle as a coin: cancel SHALL take priority, and that coin SHALL be rejected per REQ-020.
- Defined, in IDLE, VEND or CHANGE: cancel SHALL be ignored.
- Undefined: cancel SHALL be ignored in all states, and the port SHALL remain present.

Verification (PRICE = 5, CW = 4)
REQ-027 Coins 01, 10, 10 on consecutive cycles: credit goes 1, 3, then vend = 1 for one cycle with credit 0; no change; IDLE.
REQ-028 Coins 01, 01, 01, 01 then 11: credit 4, then vend, credit 4; then change_coin 10, 10 on two cycles; IDLE; busy high for 3 cycles.
REQ-029 Coin 11 from IDLE: vend for one cycle, change_coin stays 00; coin 10 during that VEND cycle: coin_reject pulses and credit is unaffected.
REQ-030 With CANCEL_EN, coins 01, 10 then cancel: change_coin 10 then 01, vend never asserts, IDLE. Without CANCEL_EN: credit holds 3.
REQ-031 rst asserted mid-CHANGE (credit 2): all outputs reach their reset values asynchronously before the next edge; a subsequent coin 01 gives credit 1.
